// File: rtl/ring_phase_step_detector.sv
// Recovers the per-sample phase step of a 16-bit ring counter stream and flags lock once the step is stable; RING_STEP_AVG_EN reports a 4-step mean instead.
// Latency: step_out/step_valid/wrap_pulse/range_err register one cycle after the phase_valid sample.
// Backpressure: none; phase_valid is accepted every cycle and idle gaps hold state.
module ring_phase_step_detector #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] START_VAL  = WIDTH'(8191),
    parameter logic [WIDTH-1:0] END_VAL    = WIDTH'(57344),
    parameter bit               DIRECTION  = 1'b0,
    parameter int               LOCK_COUNT = 4
) (
    input  logic             CLK,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] phase_in,
    input  logic             phase_valid,
    output logic [WIDTH-1:0] step_out,
    output logic             step_valid,
    output logic             wrap_pulse,
    output logic             locked,
    output logic             range_err
);

    localparam int EW = WIDTH + 2;
    localparam logic [WIDTH-1:0] LO_RAW = DIRECTION ? START_VAL : END_VAL;
    localparam logic [WIDTH-1:0] HI_RAW = DIRECTION ? END_VAL : START_VAL;
    localparam logic signed [EW-1:0] LO = {{2{LO_RAW[WIDTH-1]}}, LO_RAW};
    localparam logic signed [EW-1:0] HI = {{2{HI_RAW[WIDTH-1]}}, HI_RAW};
    localparam logic signed [EW-1:0] RANGE_SIZE = HI - LO + EW'(1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic signed [EW-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]        last_q, last_d;
    logic [3:0]              match_q, match_d;
    logic [WIDTH-1:0]        step_out_d;
    logic                    step_valid_d, wrap_d, range_err_d;

    logic signed [EW-1:0]    cur, diff;
    logic                    legal, wrap;
    logic [WIDTH-1:0]        step_raw;

`ifdef RING_STEP_AVG_EN
    logic [WIDTH-1:0]        hist_q [4];
    logic [WIDTH-1:0]        hist_d [4];
    logic [EW-1:0]           acc_q, acc_d;
    logic [2:0]              fill_q, fill_d;
`endif

    assign cur      = {{2{phase_in[WIDTH-1]}}, phase_in};
    assign legal    = (cur >= LO) && (cur <= HI);
    assign diff     = DIRECTION ? (cur - prev_q) : (prev_q - cur);
    // A negative difference means the ring wrapped between samples.
    assign wrap     = diff[EW-1];
    assign step_raw = WIDTH'(wrap ? (diff + RANGE_SIZE) : diff);

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        last_d       = last_q;
        match_d      = match_q;
        step_out_d   = step_out;
        step_valid_d = 1'b0;
        wrap_d       = 1'b0;
        range_err_d  = 1'b0;
`ifdef RING_STEP_AVG_EN
        hist_d       = hist_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
`endif
        if (phase_valid) begin
            if (!legal) begin
                range_err_d = 1'b1;
            end else if (state_q == IDLE) begin
                prev_d  = cur;
                state_d = TRACK;
            end else begin
                prev_d = cur;
                last_d = step_raw;
                if (step_raw != last_q) begin
                    match_d = 4'd1;
                    state_d = TRACK;
                end else if (state_q == TRACK) begin
                    match_d = match_q + 4'd1;
                    if (match_d == 4'(LOCK_COUNT))
                        state_d = LOCKED;
                end
`ifdef RING_STEP_AVG_EN
                // Running sum: add the newest step, drop the one leaving the window.
                acc_d     = acc_q + EW'(step_raw) - EW'(hist_q[3]);
                hist_d[0] = step_raw;
                hist_d[1] = hist_q[0];
                hist_d[2] = hist_q[1];
                hist_d[3] = hist_q[2];
                fill_d    = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
                if (fill_d == 3'd4) begin
                    step_valid_d = 1'b1;
                    wrap_d       = wrap;
                    step_out_d   = acc_d[EW-1:2];
                end
`else
                step_valid_d = 1'b1;
                wrap_d       = wrap;
                step_out_d   = step_raw;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (SCLR) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            last_q     <= '0;
            match_q    <= '0;
            step_out   <= '0;
            step_valid <= 1'b0;
            wrap_pulse <= 1'b0;
            range_err  <= 1'b0;
`ifdef RING_STEP_AVG_EN
            hist_q     <= '{default: '0};
            acc_q      <= '0;
            fill_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            last_q     <= last_d;
            match_q    <= match_d;
            step_out   <= step_out_d;
            step_valid <= step_valid_d;
            wrap_pulse <= wrap_d;
            range_err  <= range_err_d;
`ifdef RING_STEP_AVG_EN
            hist_q     <= hist_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
`endif
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: doc/ring_phase_step_detector.md
Name: ring_phase_step_detector

Overview:
- Receive-side counterpart of the 16-bit ring counter that feeds CORDIC phase.
- Observes the phase-sample stream, recovers the per-sample phase increment (step) with ring wrap-around undone, and flags lock once the step is stable.
- Sits after the phase source/CORDIC input tap; used to check the sine generator's frequency word and to close a frequency-measurement path.

Parameters:
- WIDTH, 16, phase/step data width.
- START_VAL, 16'd8191, ring start code; signed max of ring for a down ring.
- END_VAL, 16'd57344, ring end code; signed min of ring (-8192) for a down ring.
- DIRECTION, 0, 0 = phase decreases per sample (down ring), 1 = increases (up ring).
- LOCK_COUNT, 4, number of consecutive identical steps required to assert locked (range 2..15).

Ports:
- CLK  input  1  clock.
- SCLR  input  1  synchronous active-high reset, sampled on rising CLK.
- phase_in  input  WIDTH  phase sample, two's complement.
- phase_valid  input  1  phase_in valid this cycle; no backpressure.
- step_out  output  WIDTH  recovered step, unsigned, 0..RANGE_SIZE-1.
- step_valid  output  1  one-cycle strobe, step_out updated.
- wrap_pulse  output  1  one-cycle strobe with step_valid when the step crossed the ring boundary.
- locked  output  1  level; step stable for LOCK_COUNT samples.
- range_err  output  1  one-cycle strobe; phase_in outside the ring, sample discarded.

Behaviour:
- Ring bounds as signed values: LO = signed(DIRECTION ? START_VAL : END_VAL), HI = signed(DIRECTION ? END_VAL : START_VAL). RANGE_SIZE = HI - LO + 1 (16384 at defaults). All arithmetic is WIDTH+2-bit signed.
- Sample legality: the sample is legal iff LO <= signed(phase_in) <= HI.
  - An illegal sample with phase_valid pulses range_err on the next cycle.
  - It does not update prev, state, or outputs.
- Step computation: diff = DIRECTION ? (cur - prev) : (prev - cur).
  - If diff < 0: step = diff + RANGE_SIZE and wrap_pulse = 1; else step = diff and wrap_pulse = 0.
  - diff = 0 gives step 0 with no wrap.
- Latency: step_out, step_valid and wrap_pulse register 1 cycle after the phase_valid cycle of the second and later legal samples.
- FSM:
  - IDLE: no previous sample. The first legal sample stores prev, goes to TRACK, and produces no step_valid.
  - TRACK: each legal sample computes step and emits step_valid.
    - match_cnt is incremented if step == last_step, else set to 1.
    - When match_cnt reaches LOCK_COUNT, go to LOCKED.
  - LOCKED: locked = 1. On the first step != last_step, go to TRACK with match_cnt = 1. locked deasserts in the same cycle that step_valid shows the differing step.
- last_step updates on every emitted step.
- Idle gaps in phase_valid of any length are allowed; state is held.
- Reset values (any time, including mid-stream): state IDLE; prev, last_step, match_cnt, step_out = 0; step_valid, wrap_pulse, locked, range_err = 0. The sample presented in the same cycle as SCLR is ignored.

Optional Feature:
- Macro: RING_STEP_AVG_EN.
- When defined:
  - step_out is the truncated mean of the last 4 computed steps, (s0+s1+s2+s3)>>2, via a 4-deep shift register and a WIDTH+2-bit accumulator.
  - step_valid is suppressed until 4 steps have been computed since leaving IDLE.
  - Lock comparison still uses raw steps.
  - The history is cleared on SCLR and on entry to IDLE.
- When undefined: step_out is the raw instantaneous step and no averaging logic exists.

Test Plan:
- Steady down ring, defaults: phase 8191, 8091, 7991, 7891, 7791 at 1 sample/cycle -> step_out = 100 on 4 strobes, first strobe 1 cycle after the 8091 sample, wrap_pulse = 0, locked rises with the 4th step.
- Wrap: prev 0xE02A (-8150), cur 0x1FC6 (8134) -> step_out = 100, wrap_pulse = 1, locked maintained if already locked at step 100.
- Step change while locked at 100: next sample gives step 37 -> locked = 0 in the same cycle as that step_valid; re-locks after 4 consecutive steps of 37.
- Illegal input, DIRECTION = 0: phase_in = 0xC000 (-16384) -> range_err pulse, no step_valid, following legal sample diffs against the prior legal prev.
- SCLR mid-stream while locked -> next cycle all outputs 0; first post-reset sample produces no step_valid; the second gives the correct step.
- RING_STEP_AVG_EN defined: steps 100, 100, 104, 104 -> a single step_valid with step_out = 102 after the 4th step; none before.
